// File: rtl/regbank_writeback.sv
// 256x32 register bank with an ordered write-back FIFO for PRG results.
// Optional read forwarding is enabled by defining REGBANK_FWD_EN.
module regbank_writeback #(
    parameter int         DEPTH       = 4,
    parameter logic [7:0] SWITCH_ADDR = 8'h24
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        alu_wr_flag,
    input  logic [7:0]  alu_wr_addr,
    input  logic [31:0] alu_wr_data,
    input  logic        prg_wr_flag,
    input  logic [7:0]  prg_wr_addr,
    input  logic [31:0] prg_wr_data,
    input  logic [7:0]  rd_addr_a,
    input  logic [7:0]  rd_addr_b,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    output logic        switch_mode,
    output logic        wb_stall,
    output logic [3:0]  pend_count,
    output logic        wb_overflow
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    localparam logic [3:0] STALL_C = 4'(DEPTH - 1);

    logic [31:0]      regs_q  [256];
    logic [7:0]       faddr_q [DEPTH];
    logic [31:0]      fdata_q [DEPTH];
    logic [DEPTH-1:0] fvld_q;
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [3:0]       cnt_q;
    logic             ovf_q;
    logic             sw_q;

    logic        empty;
    logic        push_req;
    logic        push_en;
    logic        pop_en;
    logic        drop;
    logic        cm_en;
    logic [7:0]  cm_addr;
    logic [31:0] cm_data;

    // PRG goes direct only when nothing is queued and the ALU is idle
    assign empty    = (cnt_q == 4'd0);
    assign push_req = prg_wr_flag && !(empty && !alu_wr_flag);
    assign drop     = push_req && (cnt_q == DEPTH_C);
    assign push_en  = push_req && !drop;
    assign pop_en   = !alu_wr_flag && !empty;

    // Select the single commit of this cycle: ALU, FIFO head, or direct PRG
    always_comb begin
        cm_en   = 1'b0;
        cm_addr = 8'd0;
        cm_data = 32'd0;
        if (alu_wr_flag) begin
            cm_en   = 1'b1;
            cm_addr = alu_wr_addr;
            cm_data = alu_wr_data;
        end else if (pop_en) begin
            cm_en   = fvld_q[rptr_q];
            cm_addr = faddr_q[rptr_q];
            cm_data = fdata_q[rptr_q];
        end else if (prg_wr_flag) begin
            cm_en   = 1'b1;
            cm_addr = prg_wr_addr;
            cm_data = prg_wr_data;
        end
    end

    // Register array update
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (cm_en) begin
            regs_q[cm_addr] <= cm_data;
        end
    end

    // FIFO payload; only meaningful where the valid bit is set
    always_ff @(posedge clock) begin
        if (push_en) begin
            faddr_q[wptr_q] <= prg_wr_addr;
            fdata_q[wptr_q] <= prg_wr_data;
        end
    end

    // FIFO control: pointers, count, valid bits, overflow
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= 4'd0;
            fvld_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_wr_flag && faddr_q[i] == alu_wr_addr) begin
                    fvld_q[i] <= 1'b0;
                end
            end
            if (pop_en) begin
                fvld_q[rptr_q] <= 1'b0;
                rptr_q         <= rptr_q + 1'b1;
            end
            if (push_en) begin
                fvld_q[wptr_q] <= 1'b1;
                wptr_q         <= wptr_q + 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            if (push_en && !pop_en) begin
                cnt_q <= cnt_q + 4'd1;
            end else if (pop_en && !push_en) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Shadow of bit 0 of the switch register, updated with its commit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sw_q <= 1'b0;
        end else if (cm_en && cm_addr == SWITCH_ADDR) begin
            sw_q <= cm_data[0];
        end
    end

`ifdef REGBANK_FWD_EN
    // Current commit, then newest valid pending entry, then the array
    function automatic logic [31:0] fwd_rd(input logic [7:0] ra);
        logic [31:0]   v;
        logic [PW-1:0] idx;
        v = regs_q[ra];
        for (int k = 0; k < DEPTH; k++) begin
            idx = rptr_q + PW'(k);
            if (4'(k) < cnt_q && fvld_q[idx] && faddr_q[idx] == ra) begin
                v = fdata_q[idx];
            end
        end
        if (cm_en && cm_addr == ra) begin
            v = cm_data;
        end
        return v;
    endfunction

    assign rd_data_a = fwd_rd(rd_addr_a);
    assign rd_data_b = fwd_rd(rd_addr_b);
`else
    assign rd_data_a = regs_q[rd_addr_a];
    assign rd_data_b = regs_q[rd_addr_b];
`endif

    assign switch_mode = sw_q;
    assign wb_stall    = (cnt_q >= STALL_C);
    assign pend_count  = cnt_q;
    assign wb_overflow = ovf_q;

endmodule

// File: tb/tb_regbank_writeback.sv
// Directed self-checking bench for regbank_writeback (DEPTH = 4).
// Expectations adapt to the REGBANK_FWD_EN build option.
module tb_regbank_writeback;

    logic        clock;
    logic        reset_n;
    logic        alu_wr_flag;
    logic [7:0]  alu_wr_addr;
    logic [31:0] alu_wr_data;
    logic        prg_wr_flag;
    logic [7:0]  prg_wr_addr;
    logic [31:0] prg_wr_data;
    logic [7:0]  rd_addr_a;
    logic [7:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        switch_mode;
    logic        wb_stall;
    logic [3:0]  pend_count;
    logic        wb_overflow;

    int n_chk;
    int n_fail;

    regbank_writeback #(
        .DEPTH      (4),
        .SWITCH_ADDR(8'h24)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .alu_wr_flag(alu_wr_flag),
        .alu_wr_addr(alu_wr_addr),
        .alu_wr_data(alu_wr_data),
        .prg_wr_flag(prg_wr_flag),
        .prg_wr_addr(prg_wr_addr),
        .prg_wr_data(prg_wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .switch_mode(switch_mode),
        .wb_stall   (wb_stall),
        .pend_count (pend_count),
        .wb_overflow(wb_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_wr_flag = 1'b0;
        prg_wr_flag = 1'b0;
    endtask

    task automatic alu(input logic [7:0] a, input logic [31:0] d);
        alu_wr_flag = 1'b1;
        alu_wr_addr = a;
        alu_wr_data = d;
    endtask

    task automatic prg(input logic [7:0] a, input logic [31:0] d);
        prg_wr_flag = 1'b1;
        prg_wr_addr = a;
        prg_wr_data = d;
    endtask

    task automatic rd_a(input logic [7:0] a, input string tag,
                        input logic [31:0] exp);
        rd_addr_a = a;
        #1;
        chk(tag, rd_data_a, exp);
    endtask

    task automatic rd_b(input logic [7:0] a, input string tag,
                        input logic [31:0] exp);
        rd_addr_b = a;
        #1;
        chk(tag, rd_data_b, exp);
    endtask

    logic fwd;

    initial begin
`ifdef REGBANK_FWD_EN
        fwd = 1'b1;
`else
        fwd = 1'b0;
`endif
        n_chk       = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        alu_wr_flag = 1'b0;
        alu_wr_addr = 8'd0;
        alu_wr_data = 32'd0;
        prg_wr_flag = 1'b0;
        prg_wr_addr = 8'd0;
        prg_wr_data = 32'd0;
        rd_addr_a   = 8'd0;
        rd_addr_b   = 8'd0;

        // reset state
        tick();
        tick();
        chk("rst_pend", 32'(pend_count), 32'd0);
        chk("rst_ovf", 32'(wb_overflow), 32'd0);
        chk("rst_sw", 32'(switch_mode), 32'd0);
        chk("rst_stall", 32'(wb_stall), 32'd0);
        rd_a(8'd1, "rst_rd", 32'd0);
        reset_n = 1'b1;

        // first commit right after reset release
        alu(8'd1, 32'hDEAD_0001);
        tick();
        idle();
        rd_a(8'd1, "first_alu", 32'hDEAD_0001);

        // ALU and PRG together: ALU commits, PRG queued
        alu(8'd5, 32'h11);
        prg(8'd6, 32'h22);
        tick();
        idle();
        rd_a(8'd5, "both_alu", 32'h11);
        chk("both_pend1", 32'(pend_count), 32'd1);
        rd_b(8'd6, "both_prg_q", fwd ? 32'h22 : 32'h0);
        tick();
        rd_b(8'd6, "both_prg_drn", 32'h22);
        chk("both_pend0", 32'(pend_count), 32'd0);

        // PRG alone on an empty FIFO commits directly
        prg(8'd10, 32'h33);
        tick();
        idle();
        rd_a(8'd10, "prg_direct", 32'h33);
        chk("prg_dir_pend", 32'(pend_count), 32'd0);

        // ALU write supersedes a pending PRG to the same address
        alu(8'd20, 32'h2020);
        prg(8'd9, 32'hAA);
        tick();
        idle();
        alu(8'd9, 32'hBB);
        tick();
        idle();
        chk("inv_pend1", 32'(pend_count), 32'd1);
        tick();
        chk("inv_pend0", 32'(pend_count), 32'd0);
        rd_a(8'd9, "inv_newest", 32'hBB);

        // pop plus push keeps count; PRG order preserved
        alu(8'd30, 32'h300);
        prg(8'd40, 32'h4040);
        tick();
        idle();
        prg(8'd41, 32'h4141);
        tick();
        idle();
        chk("popush_pend", 32'(pend_count), 32'd1);
        rd_a(8'd40, "popush_40", 32'h4040);
        rd_b(8'd41, "popush_41q", fwd ? 32'h4141 : 32'h0);
        tick();
        rd_b(8'd41, "popush_41", 32'h4141);
        chk("popush_pend0", 32'(pend_count), 32'd0);

        // switch register bit 0
        prg(8'h24, 32'd1);
        tick();
        idle();
        chk("sw_set", 32'(switch_mode), 32'd1);
        prg(8'h24, 32'd0);
        tick();
        idle();
        chk("sw_clr", 32'(switch_mode), 32'd0);

        // pending PRG visible only through forwarding
        alu(8'd50, 32'h5050);
        prg(8'd7, 32'h55);
        tick();
        idle();
        rd_a(8'd7, "fwd_pend", fwd ? 32'h55 : 32'h0);
        tick();
        rd_a(8'd7, "fwd_drn", 32'h55);

        // fill past capacity while the ALU is busy every cycle
        for (int i = 0; i < 6; i++) begin
            alu(8'(100 + i), 32'(32'hA00 + i));
            prg(8'd3, 32'(i + 1));
            tick();
            if (i == 1) chk("stall_lo", 32'(wb_stall), 32'd0);
            if (i == 2) chk("stall_hi", 32'(wb_stall), 32'd1);
            if (i == 3) chk("ovf_lo", 32'(wb_overflow), 32'd0);
        end
        idle();
        chk("full_pend", 32'(pend_count), 32'd4);
        chk("full_ovf", 32'(wb_overflow), 32'd1);
        rd_a(8'd105, "full_alu", 32'hA05);
        for (int i = 0; i < 4; i++) tick();
        chk("drain_pend", 32'(pend_count), 32'd0);
        chk("drain_stall", 32'(wb_stall), 32'd0);
        chk("ovf_sticky", 32'(wb_overflow), 32'd1);
        rd_a(8'd3, "drain_val", 32'd4);

        // reset with entries pending discards them
        alu(8'h24, 32'd1);
        prg(8'd60, 32'h60);
        tick();
        alu(8'd70, 32'h70);
        prg(8'd61, 32'h61);
        tick();
        prg(8'd62, 32'h62);
        tick();
        idle();
        chk("pre_rst_pend", 32'(pend_count), 32'd3);
        chk("pre_rst_sw", 32'(switch_mode), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pend", 32'(pend_count), 32'd0);
        chk("mid_rst_ovf", 32'(wb_overflow), 32'd0);
        chk("mid_rst_sw", 32'(switch_mode), 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rd_a(8'd60, "post_rst_60", 32'd0);
        rd_b(8'd62, "post_rst_62", 32'd0);
        rd_a(8'd1, "post_rst_1", 32'd0);
        chk("post_rst_pend", 32'(pend_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regbank_writeback.md
REGBANK_WRITEBACK -- requirements
Module: regbank_writeback

Interface
- REQ-001: Parameter DEPTH, default 4, sets the number of pending-write FIFO entries (power of two, 2..8).
- REQ-002: Parameter SWITCH_ADDR, default 8'h24, is the register address whose bit 0 drives switch_mode.
- REQ-003: clock  input  1  single clock; all state updates on posedge.
- REQ-004: reset_n  input  1  asynchronous, active-low reset.
- REQ-005: alu_wr_flag / alu_wr_addr / alu_wr_data  input  1/8/32  ALU write-back request, addressed register and data.
- REQ-006: prg_wr_flag / prg_wr_addr / prg_wr_data  input  1/8/32  program-counter-unit write-back (POP, GSA, SWITCH results).
- REQ-007: rd_addr_a, rd_addr_b  input  8  read port addresses.
- REQ-008: rd_data_a, rd_data_b  output  32  read port data, combinational.
- REQ-009: switch_mode  output  1  bit 0 of register SWITCH_ADDR.
- REQ-010: wb_stall  output  1  high when pending count >= DEPTH-1; upstream holds new prg writes while it is high.
- REQ-011: pend_count  output  4  number of valid pending entries.
- REQ-012: wb_overflow  output  1  sticky flag set when a prg write is dropped because the FIFO is full.

Function
- REQ-013: The register array SHALL be 256 x 32, and every register SHALL be writable.
- REQ-014: When only alu_wr_flag is high and the FIFO is empty, the ALU write SHALL commit at that posedge.
- REQ-015: When only prg_wr_flag is high, the FIFO is empty and no ALU write is present, the PRG write SHALL commit at that posedge.
- REQ-016: When both flags are high in one cycle, the ALU write SHALL commit and the PRG write SHALL be pushed to the FIFO.
- REQ-017: While the FIFO is non-empty, every new PRG write SHALL be pushed, never committed directly, so PRG order is preserved.
- REQ-018: In any cycle with alu_wr_flag low and the FIFO non-empty, the head entry SHALL commit (if valid) and be popped, giving one drain per idle cycle.
- REQ-019: A simultaneous pop and push SHALL leave pend_count unchanged.
- REQ-020: An ALU write SHALL clear the valid bit of every pending entry with the same address (newest wins); an invalid head SHALL pop without committing.
- REQ-021: A push while pend_count == DEPTH SHALL be dropped and SHALL set wb_overflow, with no other state change.
- REQ-022: The FIFO pointers SHALL wrap modulo DEPTH, and pend_count SHALL never exceed DEPTH.
- REQ-023: rd_data_a and rd_data_b SHALL return array contents combinationally.
- REQ-024: switch_mode SHALL follow the array value after commit, updating the cycle after a commit to SWITCH_ADDR.
- REQ-025: Two commits in one cycle are impossible by construction, because the FIFO drains only when the ALU is idle.

Reset
- REQ-026: While reset_n is low, all registers, FIFO pointers, valid bits, pend_count, wb_overflow and switch_mode SHALL be 0, immediately and independent of clock.
- REQ-027: A reset asserted mid-drain SHALL discard all pending entries.
- REQ-028: The first commit SHALL occur at the first posedge after reset_n rises.

Configuration
- REQ-029: With REGBANK_FWD_EN defined, each read port SHALL return, in priority order, the data being committed this cycle to a matching address, else the newest valid pending entry with a matching address, else array contents.
- REQ-030: Without REGBANK_FWD_EN, read ports SHALL return array contents only; the forwarding logic SHALL be absent.

Verification
- REQ-031: Scenario: ALU writes 0x11 to addr 5 and PRG writes 0x22 to addr 6 in the same cycle -> addr 5 = 0x11 that cycle; pend_count = 1; addr 6 = 0x22 one idle cycle later; pend_count = 0.
- REQ-032: Scenario: PRG writes to addr 3 every cycle for 6 cycles while the ALU writes every cycle, DEPTH = 4 -> wb_stall rises at count 3; 5th and 6th pushes dropped; wb_overflow = 1; pend_count = 4.
- REQ-033: Scenario: PRG 0xAA to addr 9 is pending, then ALU writes 0xBB to addr 9 -> after drain, addr 9 = 0xBB, not 0xAA.
- REQ-034: Scenario: PRG writes 1 to addr 0x24 -> switch_mode = 1 the next cycle; a later write of 0 -> switch_mode = 0.
- REQ-035: Scenario: with REGBANK_FWD_EN defined, PRG 0x55 to addr 7 is pending and rd_addr_a = 7 -> rd_data_a = 0x55 before the drain; without the macro, rd_data_a = 0.
- REQ-036: Scenario: reset_n pulled low with 3 entries pending -> pend_count, wb_overflow and switch_mode = 0 immediately; no pending data is committed after release.
